brp_gshare: RTL and testbench

Parametrised gshare branch direction predictor for the RV32I pipeline. It replaces the fixed bimodal direction table inside the branch-prediction wrapper. The block XORs fetch-PC bits with a global history register to index a pattern history table (PHT) of 2-bit saturating counters. It returns a same-cycle taken/not-taken prediction plus the PHT index, which the pipeline carries to EX. The PHT, history and saturating accuracy counters are trained from EX resolution, and the PHT is initialised by a post-reset sweep.

---
 rtl/brp_gshare.sv | 119 +++++++++++
 tb/tb_brp_gshare.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/brp_gshare.sv
// gshare branch direction predictor.
// Fetch-PC bits XOR global history index a table of 2-bit saturating
// counters. Prediction is combinational; training, history shift and
// accuracy counting happen at EX resolution. A post-reset sweep loads
// every table entry with INIT_CTR before predictions go live.
module brp_gshare #(
  parameter int         IDX_W    = 8,
  parameter int         HIST_W   = 8,
  parameter int         CNT_W    = 32,
  parameter logic [1:0] INIT_CTR = 2'b01
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic [31:0]       req_pc,
  output logic              ready,
  output logic              pred_taken,
  output logic [IDX_W-1:0]  pred_idx,
  input  logic              upd_valid,
  input  logic [IDX_W-1:0]  upd_idx,
  input  logic              upd_taken,
  input  logic              upd_mispredict,
  output logic [HIST_W-1:0] ghr,
  output logic [CNT_W-1:0]  c_total,
  output logic [CNT_W-1:0]  c_correct
);

  localparam int DEPTH = 2 ** IDX_W;

  typedef enum logic {S_INIT, S_RUN} state_t;

  state_t              state;
  state_t              state_nx;
  logic [IDX_W-1:0]    sweep_ptr;
  logic [1:0]          pht [DEPTH];
  logic [IDX_W-1:0]    hist_ext;
  logic [IDX_W-1:0]    idx;
  logic [HIST_W-1:0]   ghr_nx;
  logic                req_en;
  logic                upd_en;
  logic                pc_unused;

  // 2-bit counter step toward the resolved direction, clamped at 0 and 3.
  function automatic logic [1:0] ctr_step(input logic [1:0] ctr, input logic taken);
    if (taken) return (ctr == 2'd3) ? ctr : ctr + 2'd1;
    else       return (ctr == 2'd0) ? ctr : ctr - 2'd1;
  endfunction

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + CNT_W'(1);
  endfunction

  // Only PC[IDX_W+1:2] feed the hash; the rest are deliberately ignored.
  assign pc_unused = ^{req_pc[31:IDX_W+2], req_pc[1:0]};

  // History is zero-extended into the low bits of the index.
  always_comb begin
    hist_ext = '0;
    hist_ext[HIST_W-1:0] = ghr;
  end

  assign idx = req_pc[IDX_W+1:2] ^ hist_ext;

  // Shift the resolved outcome into the history (single-bit history just takes it).
  if (HIST_W == 1) begin : g_hist1
    assign ghr_nx = upd_taken;
  end else begin : g_histn
    assign ghr_nx = {ghr[HIST_W-2:0], upd_taken};
  end

  // Next-state and ready: sweep until the last entry is written, then run.
  always_comb begin
    state_nx = state;
    ready    = 1'b0;
    case (state)
      S_INIT: if (&sweep_ptr) state_nx = S_RUN;
      S_RUN:  ready = 1'b1;
      default: state_nx = S_INIT;
    endcase
  end

  // State register; rst always restarts the sweep.
  always_ff @(posedge clk) begin
    if (rst) state <= S_INIT;
    else     state <= state_nx;
  end

  assign req_en     = ready & req_valid;
  assign upd_en     = ready & upd_valid;
  assign pred_taken = req_en & pht[idx][1];
  assign pred_idx   = req_en ? idx : '0;

  // Sweep pointer, history and accuracy counters; updates ignored while sweeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      sweep_ptr <= '0;
      ghr       <= '0;
      c_total   <= '0;
      c_correct <= '0;
    end else begin
      if (state == S_INIT) sweep_ptr <= sweep_ptr + IDX_W'(1);
      if (upd_en) begin
        ghr     <= ghr_nx;
        c_total <= sat_inc(c_total);
        if (!upd_mispredict) c_correct <= sat_inc(c_correct);
      end
    end
  end

  // Single PHT write port: sweep fill in INIT, counter training in RUN.
  always_ff @(posedge clk) begin
    if (state == S_INIT)
      pht[sweep_ptr] <= INIT_CTR;
    else if (upd_valid)
      pht[upd_idx] <= ctr_step(pht[upd_idx], upd_taken);
  end

endmodule

// File: tb/tb_brp_gshare.sv
// Directed bench for brp_gshare (IDX_W=HIST_W=4, CNT_W=3) with a
// cycle-stamped expectation queue drained by an independent monitor.
module tb_brp_gshare;

  localparam int IDX_W  = 4;
  localparam int HIST_W = 4;
  localparam int CNT_W  = 3;

  localparam int F_READY = 0;
  localparam int F_PT    = 1;
  localparam int F_PIDX  = 2;
  localparam int F_GHR   = 3;
  localparam int F_TOT   = 4;
  localparam int F_COR   = 5;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              req_valid = 1'b0;
  logic [31:0]       req_pc = '0;
  logic              ready;
  logic              pred_taken;
  logic [IDX_W-1:0]  pred_idx;
  logic              upd_valid = 1'b0;
  logic [IDX_W-1:0]  upd_idx = '0;
  logic              upd_taken = 1'b0;
  logic              upd_mispredict = 1'b0;
  logic [HIST_W-1:0] ghr;
  logic [CNT_W-1:0]  c_total;
  logic [CNT_W-1:0]  c_correct;

  brp_gshare #(.IDX_W(IDX_W), .HIST_W(HIST_W), .CNT_W(CNT_W), .INIT_CTR(2'b01)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_pc(req_pc),
    .ready(ready), .pred_taken(pred_taken), .pred_idx(pred_idx),
    .upd_valid(upd_valid), .upd_idx(upd_idx), .upd_taken(upd_taken),
    .upd_mispredict(upd_mispredict), .ghr(ghr),
    .c_total(c_total), .c_correct(c_correct)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    int          fld;
    logic [31:0] val;
    string       name;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;

  int mp10  [10] = '{0, 1, 0, 0, 1, 0, 0, 0, 0, 0};
  int tot10 [10] = '{1, 2, 3, 4, 5, 6, 7, 7, 7, 7};
  int cor10 [10] = '{1, 1, 2, 3, 3, 4, 5, 6, 7, 7};

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: compare every expectation stamped for this cycle.
  exp_t        mon_e;
  logic [31:0] mon_act;
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      mon_e = q.pop_front();
      case (mon_e.fld)
        F_READY: mon_act = 32'(ready);
        F_PT:    mon_act = 32'(pred_taken);
        F_PIDX:  mon_act = 32'(pred_idx);
        F_GHR:   mon_act = 32'(ghr);
        F_TOT:   mon_act = 32'(c_total);
        default: mon_act = 32'(c_correct);
      endcase
      n_chk++;
      if (mon_e.cyc != cyc || mon_act !== mon_e.val) begin
        n_fail++;
        $display("FAIL %s (cycle %0d): got %0h, expected %0h", mon_e.name, mon_e.cyc, mon_act, mon_e.val);
      end
    end
  end

  task automatic exp_push(input int fld, input logic [31:0] val, input string name);
    exp_t e;
    e.cyc = cyc; e.fld = fld; e.val = val; e.name = name;
    q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic rv, input logic [31:0] pc, input logic uv,
                       input logic [3:0] ui, input logic ut, input logic um);
    req_valid = rv; req_pc = pc;
    upd_valid = uv; upd_idx = ui; upd_taken = ut; upd_mispredict = um;
  endtask

  // Reset, then walk the 16-cycle sweep; optionally fire updates during it.
  task automatic do_reset(input bit upd_in_init);
    step();
    rst = 1'b1;
    drive(1'b1, 32'h0000_0040, 1'b0, 4'd0, 1'b0, 1'b0);
    step();
    exp_push(F_READY, 0, "rst_ready");
    exp_push(F_PT, 0, "rst_pred_taken");
    exp_push(F_PIDX, 0, "rst_pred_idx");
    exp_push(F_GHR, 0, "rst_ghr");
    exp_push(F_TOT, 0, "rst_c_total");
    exp_push(F_COR, 0, "rst_c_correct");
    step();
    rst = 1'b0;
    for (int k = 0; k < 16; k++) begin
      drive(1'b0, 32'h0, upd_in_init, 4'(k), 1'b1, 1'b0);
      exp_push(F_READY, 0, "init_ready_low");
      if (upd_in_init) begin
        exp_push(F_TOT, 0, "init_upd_c_total");
        exp_push(F_GHR, 0, "init_upd_ghr");
      end
      step();
    end
    drive(1'b0, 32'h0, 1'b0, 4'd0, 1'b0, 1'b0);
    exp_push(F_READY, 1, "init_ready_high");
    exp_push(F_TOT, 0, "post_init_c_total");
    exp_push(F_GHR, 0, "post_init_ghr");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset and sweep, with updates offered during the sweep.
    do_reset(1'b1);
    n_chk++;
    if (ready !== 1'b1) begin
      n_fail++;
      $display("FAIL direct_ready_after_init: got %0h, expected 1", ready);
    end
    n_chk++;
    if (c_total !== 3'd0) begin
      n_fail++;
      $display("FAIL direct_c_total_after_init: got %0h, expected 0", c_total);
    end
    n_chk++;
    if (ghr !== 4'h0) begin
      n_fail++;
      $display("FAIL direct_ghr_after_init: got %0h, expected 0", ghr);
    end
    step();
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 32'(i << 2), 1'b0, 4'd0, 1'b0, 1'b0);
      exp_push(F_PT, 0, "init_read_pred_taken");
      exp_push(F_PIDX, 32'(i), "init_read_pred_idx");
      step();
    end

    // Saturation on entry 0; req_pc tracks ghr so the index stays 0.
    drive(1'b1, 32'h40, 1'b1, 4'd0, 1'b1, 1'b1);
    exp_push(F_PT, 0, "sat_a_pt"); exp_push(F_PIDX, 0, "sat_a_idx");
    step();
    drive(1'b1, 32'h44, 1'b1, 4'd0, 1'b1, 1'b0);
    exp_push(F_PT, 1, "sat_b_pt"); exp_push(F_PIDX, 0, "sat_b_idx"); exp_push(F_GHR, 4'h1, "sat_b_ghr");
    step();
    drive(1'b1, 32'h4C, 1'b1, 4'd0, 1'b1, 1'b0);
    exp_push(F_PT, 1, "sat_c_pt"); exp_push(F_GHR, 4'h3, "sat_c_ghr");
    step();
    drive(1'b1, 32'h5C, 1'b1, 4'd0, 1'b1, 1'b0);
    exp_push(F_PT, 1, "sat_d_pt"); exp_push(F_GHR, 4'h7, "sat_d_ghr");
    step();
    drive(1'b1, 32'h7C, 1'b1, 4'd0, 1'b0, 1'b1);
    exp_push(F_PT, 1, "sat_e_pt"); exp_push(F_PIDX, 0, "sat_e_idx");
    step();
    drive(1'b1, 32'h78, 1'b1, 4'd0, 1'b0, 1'b1);
    exp_push(F_PT, 1, "sat_f_pt"); exp_push(F_GHR, 4'hE, "sat_f_ghr");
    step();
    drive(1'b1, 32'h70, 1'b0, 4'd0, 1'b0, 1'b0);
    exp_push(F_PT, 0, "sat_g_pt"); exp_push(F_PIDX, 0, "sat_g_idx");
    exp_push(F_GHR, 4'hC, "sat_g_ghr");
    exp_push(F_TOT, 6, "sat_c_total"); exp_push(F_COR, 3, "sat_c_correct");
    step();

    // History hashing: T, NT, T -> ghr 0101.
    do_reset(1'b0);
    step();
    drive(1'b0, 32'h0, 1'b1, 4'd3, 1'b1, 1'b0);
    step();
    drive(1'b0, 32'h0, 1'b1, 4'd4, 1'b0, 1'b0);
    exp_push(F_GHR, 4'h1, "hist_ghr1");
    step();
    drive(1'b0, 32'h0, 1'b1, 4'd6, 1'b1, 1'b0);
    exp_push(F_GHR, 4'h2, "hist_ghr2");
    step();
    drive(1'b1, 32'h3C, 1'b0, 4'd0, 1'b0, 1'b0);
    exp_push(F_GHR, 4'h5, "hist_ghr3");
    exp_push(F_PIDX, 4'hA, "hist_pred_idx"); exp_push(F_PT, 0, "hist_pred_taken");
    step();
    drive(1'b0, 32'h18, 1'b0, 4'd0, 1'b0, 1'b0);
    exp_push(F_PT, 0, "noreq_pred_taken"); exp_push(F_PIDX, 0, "noreq_pred_idx");
    step();
    drive(1'b1, 32'h18, 1'b0, 4'd0, 1'b0, 1'b0);
    exp_push(F_PT, 1, "req_idx3_pred_taken"); exp_push(F_PIDX, 4'h3, "req_idx3_pred_idx");
    step();

    // Drive ghr to 1111 so a taken update leaves the hash unchanged.
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, 32'h0, 1'b1, 4'd9, 1'b1, 1'b0);
      step();
    end
    // Same-cycle read/update of entry 5: old counter this cycle, new next.
    drive(1'b1, 32'h28, 1'b1, 4'd5, 1'b1, 1'b0);
    exp_push(F_GHR, 4'hF, "haz_ghr_before");
    exp_push(F_PT, 0, "haz_same_cycle_pt"); exp_push(F_PIDX, 4'h5, "haz_same_cycle_idx");
    step();
    drive(1'b1, 32'h28, 1'b0, 4'd0, 1'b0, 1'b0);
    exp_push(F_PT, 1, "haz_next_cycle_pt"); exp_push(F_PIDX, 4'h5, "haz_next_cycle_idx");
    exp_push(F_GHR, 4'hF, "haz_ghr_after");
    step();

    // Accuracy counters saturating at 7.
    do_reset(1'b0);
    step();
    for (int k = 0; k < 10; k++) begin
      drive(1'b0, 32'h0, 1'b1, 4'd7, 1'b1, 1'(mp10[k]));
      if (k > 0) begin
        exp_push(F_TOT, 32'(tot10[k-1]), "cnt_c_total");
        exp_push(F_COR, 32'(cor10[k-1]), "cnt_c_correct");
      end
      step();
    end
    drive(1'b0, 32'h0, 1'b0, 4'd0, 1'b0, 1'b0);
    exp_push(F_TOT, 32'(tot10[9]), "cnt_final_c_total");
    exp_push(F_COR, 32'(cor10[9]), "cnt_final_c_correct");
    step();

    // Short run after reset: 3 updates, 1 mispredict.
    do_reset(1'b0);
    step();
    drive(1'b0, 32'h0, 1'b1, 4'd7, 1'b1, 1'b0); step();
    drive(1'b0, 32'h0, 1'b1, 4'd7, 1'b1, 1'b1); step();
    drive(1'b0, 32'h0, 1'b1, 4'd7, 1'b1, 1'b0); step();
    drive(1'b1, 32'h0, 1'b0, 4'd0, 1'b0, 1'b0);
    exp_push(F_TOT, 3, "cnt3_c_total"); exp_push(F_COR, 2, "cnt3_c_correct");
    exp_push(F_GHR, 4'h7, "cnt3_ghr");
    exp_push(F_PT, 1, "pre_mid_idx7_pt"); exp_push(F_PIDX, 4'h7, "pre_mid_idx7_idx");
    n_chk++;
    if (c_total !== 3'd3) begin
      n_fail++;
      $display("FAIL direct_cnt3_c_total: got %0h, expected 3", c_total);
    end
    n_chk++;
    if (c_correct !== 3'd2) begin
      n_fail++;
      $display("FAIL direct_cnt3_c_correct: got %0h, expected 2", c_correct);
    end
    step();

    // Reset at cycle 7 of the sweep; sweep restarts and takes 16 cycles again.
    rst = 1'b1;
    drive(1'b0, 32'h0, 1'b0, 4'd0, 1'b0, 1'b0);
    step();
    rst = 1'b0;
    for (int k = 0; k < 7; k++) step();
    rst = 1'b1;
    exp_push(F_READY, 0, "mid_ready_at_c7");
    step();
    rst = 1'b0;
    for (int k = 0; k < 16; k++) begin
      exp_push(F_READY, 0, "mid_restart_ready_low");
      step();
    end
    drive(1'b1, 32'h1C, 1'b0, 4'd0, 1'b0, 1'b0);
    exp_push(F_READY, 1, "mid_restart_ready_high");
    exp_push(F_TOT, 0, "mid_restart_c_total");
    exp_push(F_PT, 0, "mid_restart_idx7_pt"); exp_push(F_PIDX, 4'h7, "mid_restart_idx7_idx");
    step();
    drive(1'b0, 32'h0, 1'b0, 4'd0, 1'b0, 1'b0);

    // Drain the queue with a bounded wait.
    for (int k = 0; k < 4 && q.size() > 0; k++) step();
    while (q.size() > 0) begin
      mon_e = q.pop_front();
      n_chk++;
      n_fail++;
      $display("FAIL %s: never checked, expected %0h", mon_e.name, mon_e.val);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
